// File: rtl/instr_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_bus_pkg
//  Purpose  : Shared types and constants for the instruction fetch bus
//             responder: the response pipeline entry and word geometry.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package instr_bus_pkg;

  localparam int unsigned INSTR_WORD_BYTES = 4;
  localparam logic [31:0] INSTR_ERR_RDATA  = 32'h0;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } instr_rsp_t;

endpackage
`default_nettype wire

// File: rtl/instr_rsp_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : instr_rsp_pipe
//  Purpose  : LATENCY-deep shift register of fetch responses. Stage 0 is
//             loaded on every edge; the last stage drives the bus response.
//             Asynchronous clear discards everything in flight.
//  Ports    : clk    - clock
//             rstn   - asynchronous active-low reset
//             rsp_i  - response entering stage 0
//             rsp_o  - response leaving the last stage
//  Revision : 1.0 - initial release
// ============================================================================
module instr_rsp_pipe
  import instr_bus_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  instr_rsp_t rsp_i,
  output instr_rsp_t rsp_o
);

  instr_rsp_t [LATENCY-1:0] stage_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= rsp_i;
      for (int i = 1; i < int'(LATENCY); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign rsp_o = stage_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_responder
//  Purpose  : Memory end of the instruction fetch bus. Word-addressed store,
//             combinational grant limited by an outstanding-request counter,
//             in-order responses after a fixed LATENCY. A side load port
//             fills the program image.
//  Ports    : clk, rstn                  - clock, async active-low reset
//             instr_req_i / instr_gnt_o  - fetch request / grant
//             instr_addr_i               - fetch byte address
//             instr_rdata_o              - read data (valid with rvalid)
//             instr_rvalid_o             - one pulse per granted request
//             instr_err_o                - out-of-range fetch
//             load_we_i/addr_i/wdata_i   - image write port
//  Options  : INSTR_MEM_RAND_STALL_EN - LFSR-driven grant suppression
//  Revision : 1.0 - initial release
// ============================================================================
module instr_mem_responder
  import instr_bus_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 1,   // 1..8
  parameter int unsigned NUM_OUTSTANDING = 2,   // 1..LATENCY+1
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i
);

  localparam int unsigned     IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned     CNT_W       = $clog2(NUM_OUTSTANDING + 1);
  localparam int unsigned     WORD_SHIFT  = $clog2(INSTR_WORD_BYTES);
  localparam logic [CNT_W-1:0] MAX_OUT    = CNT_W'(NUM_OUTSTANDING);
  localparam logic [31:0]     MEM_WORDS_W = 32'(MEM_WORDS);

  // --------------------------------------------------------------------------
  // Address decode: low byte-offset bits fall away in the shift, so the full
  // aligned word is always returned.
  // --------------------------------------------------------------------------
  logic [31:0]      w_fetch_word;
  logic             w_fetch_ok;
  logic [IDX_W-1:0] w_fetch_idx;
  logic [31:0]      w_load_word;
  logic             w_load_ok;
  logic [IDX_W-1:0] w_load_idx;

  assign w_fetch_word = (instr_addr_i - BASE_ADDR) >> WORD_SHIFT;
  assign w_fetch_ok   = (instr_addr_i >= BASE_ADDR) && (w_fetch_word < MEM_WORDS_W);
  assign w_fetch_idx  = w_fetch_word[IDX_W-1:0];

  assign w_load_word  = (load_addr_i - BASE_ADDR) >> WORD_SHIFT;
  assign w_load_ok    = (load_addr_i >= BASE_ADDR) && (w_load_word < MEM_WORDS_W);
  assign w_load_idx   = w_load_word[IDX_W-1:0];

  // --------------------------------------------------------------------------
  // Instruction store (not reset). A same-edge load and fetch of one word
  // return the old contents because both sides sample before the update.
  // --------------------------------------------------------------------------
  logic [31:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (load_we_i && w_load_ok) begin
      mem_q[w_load_idx] <= load_wdata_i;
    end
  end

  // --------------------------------------------------------------------------
  // Optional stall injection
  // --------------------------------------------------------------------------
  logic w_stall;

`ifdef INSTR_MEM_RAND_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Fibonacci form, taps 16,14,13,11 (bits 0,2,3,5 in right-shift order).
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign w_stall = (lfsr_q[1:0] == 2'b00);
`else
  logic w_unused_seed;
  assign w_unused_seed = ^LFSR_SEED;
  assign w_stall       = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Grant and outstanding counter. Grant never depends on the address, and a
  // slot freed by rvalid is only visible to the grant one cycle later.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] out_cnt_q;
  logic [CNT_W-1:0] out_cnt_d;
  logic             w_gnt;
  instr_rsp_t       w_rsp_in;
  instr_rsp_t       w_rsp_out;

  assign w_gnt       = rstn & instr_req_i & (out_cnt_q < MAX_OUT) & ~w_stall;
  assign instr_gnt_o = w_gnt;

  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({w_gnt, w_rsp_out.valid})
      2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
      2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_cnt_q <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response pipeline
  // --------------------------------------------------------------------------
  always_comb begin
    w_rsp_in = '0;
    if (w_gnt) begin
      w_rsp_in.valid = 1'b1;
      w_rsp_in.err   = ~w_fetch_ok;
      w_rsp_in.rdata = w_fetch_ok ? mem_q[w_fetch_idx] : INSTR_ERR_RDATA;
    end
  end

  instr_rsp_pipe #(
    .LATENCY (LATENCY)
  ) u_rsp_pipe (
    .clk   (clk),
    .rstn  (rstn),
    .rsp_i (w_rsp_in),
    .rsp_o (w_rsp_out)
  );

  assign instr_rvalid_o = w_rsp_out.valid;
  assign instr_err_o    = w_rsp_out.err;
  assign instr_rdata_o  = w_rsp_out.rdata;

  // --------------------------------------------------------------------------
  // Counter must stay within bounds.
  // --------------------------------------------------------------------------
  a_cnt_saturate : assert property (@(posedge clk) disable iff (!rstn)
    out_cnt_q <= MAX_OUT);
  a_cnt_no_underflow : assert property (@(posedge clk) disable iff (!rstn)
    w_rsp_out.valid |-> (out_cnt_q != '0));

endmodule
`default_nettype wire
